pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard and stall controller for a five-stage in-order pipeline. Each cycle
//   it decides whether the fetch, decode, execute and memory pipeline registers
//   hold or take a nop, and whether fetch reloads its PC from a redirect target.
//   Three hazards are resolved in fixed priority:
//     1. data-memory miss      (m_req && !m_ok)  - freeze F/D/E/M, bubble W
//     2. load-use              (e_dstM feeds D)  - freeze F/D, bubble E
//     3. instruction-fetch wait (!i_ok)          - freeze F, bubble D
//   A redirect resolved in decode while the fetch is still outstanding is
//   remembered (DROP state) so the late wrong-path instruction is discarded.
//
// Ports
//   clk              in   clock, all state on rising edge
//   reset            in   synchronous active-high reset
//   d_srcA, d_srcB   in   decode-stage source register ids       [REG_W]
//   d_useA, d_useB   in   corresponding source is read
//   e_dstM           in   load destination in execute, 0 = none  [REG_W]
//   d_redirect       in   decode resolved a taken branch/jump
//   i_ok             in   fetch data valid this cycle
//   m_req, m_ok      in   memory stage access present / completes
//   stall_F..stall_M out  hold the respective pipeline register
//   bubble_D/E/W     out  load a nop into the respective pipeline register
//   flush_F          out  fetch reloads PC from the redirect target
//   stall_cnt        out  number of cycles with stall_F high     [CNT_W]
//   mem_err          out  sticky data-memory timeout flag
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int REG_W   = 5,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255   // must be >= 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_srcA,
  input  logic [REG_W-1:0] d_srcB,
  input  logic             d_useA,
  input  logic             d_useB,
  input  logic [REG_W-1:0] e_dstM,
  input  logic             d_redirect,
  input  logic             i_ok,
  input  logic             m_req,
  input  logic             m_ok,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             bubble_D,
  output logic             bubble_E,
  output logic             bubble_W,
  output logic             flush_F,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] W_TMO = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {RUN, IWAIT, DROP, DWAIT} state_t;

  state_t              r_state;
  state_t              w_next;
  state_t              w_eff;        // state whose fetch rules apply this cycle
  logic                r_pend;       // DROP was interrupted by a data miss
  logic                w_pend_next;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_err;
  logic                r_flush;      // flush_F was high last cycle
  logic [CNT_W-1:0]    r_stall_cnt;

  logic w_dmiss;
  logic w_lduse;
  logic w_redir;

  assign w_dmiss = m_req && !m_ok;
  assign w_lduse = (e_dstM != '0) &&
                   ((d_useA && (d_srcA == e_dstM)) || (d_useB && (d_srcB == e_dstM)));
  // The cycle after a flush, decode holds the bubble inserted by that flush, so
  // any redirect seen there is stale; masking it also keeps flush_F from ever
  // pulsing two cycles in a row.
  assign w_redir = d_redirect && !r_flush;

  // The cycle the data memory completes behaves like the state we return to,
  // so a late fetch or a deferred wrong-path drop is handled without delay.
  assign w_eff = (r_state == DWAIT) ? (r_pend ? DROP : RUN) : r_state;

  // NOTE: every signal written in this block gets a default first; a path that
  //       leaves one unassigned would infer a latch.
  always_comb begin
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    stall_E     = 1'b0;
    stall_M     = 1'b0;
    bubble_D    = 1'b0;
    bubble_E    = 1'b0;
    bubble_W    = 1'b0;
    flush_F     = 1'b0;
    w_next      = r_state;
    w_pend_next = r_pend;

    if (reset) begin
      // outputs stay quiet; the register block forces the state
    end else if (w_dmiss) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      bubble_W = 1'b1;
      w_next   = DWAIT;
      // Remember an outstanding wrong-path fetch only on entry; inside DWAIT
      // the saved value must survive.
      if (r_state != DWAIT) w_pend_next = (r_state == DROP);
    end else if (w_lduse) begin
      stall_F     = 1'b1;
      stall_D     = 1'b1;
      bubble_E    = 1'b1;
      w_next      = w_eff;
      w_pend_next = 1'b0;
    end else begin
      w_pend_next = 1'b0;
      case (w_eff)
        DROP: begin
          bubble_D = 1'b1;
          if (i_ok) begin
            flush_F = 1'b1;
            w_next  = RUN;
          end else begin
            stall_F = 1'b1;
            w_next  = DROP;
          end
        end
        default: begin  // RUN and IWAIT follow identical rules
          if (!i_ok) begin
            stall_F  = 1'b1;
            bubble_D = 1'b1;
            w_next   = w_redir ? DROP : IWAIT;
          end else begin
            w_next = RUN;
            if (w_redir) begin
              flush_F  = 1'b1;
              bubble_D = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  //       samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_pend      <= 1'b0;
      r_wait      <= '0;
      r_err       <= 1'b0;
      r_flush     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_pend      <= w_pend_next;
      r_flush     <= flush_F;
      r_stall_cnt <= r_stall_cnt + CNT_W'(stall_F);
      if ((r_state == DWAIT) && w_dmiss) begin
        // saturate so a long miss never wraps back below the threshold
        if (r_wait != W_TMO) r_wait <= r_wait + WAIT_W'(1);
        if (r_wait == W_TMO - WAIT_W'(1)) r_err <= 1'b1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign mem_err   = r_err;

endmodule
